// File: rtl/connect4_pkg.sv
// Shared definitions for the connect-four win scanner: board geometry,
// cell/direction/result encodings and the scanner FSM state type.
package connect4_pkg;

    localparam int ROWS    = 7;
    localparam int COLS    = 7;
    localparam int WIN_LEN = 4;
    localparam int NCELLS  = ROWS * COLS;
    localparam int BOARD_W = 2 * NCELLS;
    localparam int IDX_W   = 6;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;
    localparam logic [1:0] CELL_BAD   = 2'b11;

    localparam logic [1:0] DIR_H = 2'b00;
    localparam logic [1:0] DIR_V = 2'b01;
    localparam logic [1:0] DIR_D = 2'b10;
    localparam logic [1:0] DIR_A = 2'b11;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // The illegal code 11 behaves exactly like an empty cell everywhere.
    function automatic logic [1:0] cell_clean(input logic [1:0] c);
        logic [1:0] v;
        if (c == CELL_BAD) begin
            v = CELL_EMPTY;
        end else begin
            v = c;
        end
        return v;
    endfunction

endpackage

// File: rtl/win_line_check.sv
// Combinational check of one WIN_LEN line starting at (row, col) in one
// direction. A line that would leave the board never matches (no wrap).
module win_line_check
    import connect4_pkg::*;
(
    input  logic [BOARD_W-1:0] snap,
    input  logic [2:0]         row,
    input  logic [2:0]         col,
    input  logic [1:0]         dir,
    output logic               in_range,
    output logic               match
);

    logic [1:0]       cells_s [NCELLS];
    int               dr_s;
    int               dc_s;
    int               end_row_s;
    int               end_col_s;
    int               r_s;
    int               c_s;
    logic [IDX_W-1:0] idx_s;
    logic [1:0]       anchor_cell_s;
    logic             in_range_s;
    logic             match_s;

    // Unpack the board so that cell 0 (top-left) comes from the MSBs.
    for (genvar j = 0; j < NCELLS; j++) begin : g_cell
        assign cells_s[j] = cell_clean(snap[2*(NCELLS-1-j) +: 2]);
    end

    // Step vector, bounds test and cell-by-cell comparison along the line.
    always_comb begin
        dr_s          = 0;
        dc_s          = 0;
        r_s           = 0;
        c_s           = 0;
        idx_s         = '0;
        anchor_cell_s = CELL_EMPTY;
        case (dir)
            DIR_H:   begin dr_s = 0; dc_s = 1;  end
            DIR_V:   begin dr_s = 1; dc_s = 0;  end
            DIR_D:   begin dr_s = 1; dc_s = 1;  end
            DIR_A:   begin dr_s = 1; dc_s = -1; end
            default: begin dr_s = 0; dc_s = 1;  end
        endcase
        end_row_s  = int'(row) + dr_s * (WIN_LEN - 1);
        end_col_s  = int'(col) + dc_s * (WIN_LEN - 1);
        in_range_s = (int'(row) < ROWS) && (int'(col) < COLS) &&
                     (end_row_s < ROWS) && (end_col_s >= 0) && (end_col_s < COLS);
        if (in_range_s) begin
            idx_s         = IDX_W'(int'(row) * COLS + int'(col));
            anchor_cell_s = cells_s[idx_s];
        end else begin
            anchor_cell_s = CELL_EMPTY;
        end
        match_s = in_range_s && (anchor_cell_s != CELL_EMPTY);
        for (int i = 1; i < WIN_LEN; i++) begin
            r_s = int'(row) + dr_s * i;
            c_s = int'(col) + dc_s * i;
            if (in_range_s) begin
                idx_s = IDX_W'(r_s * COLS + c_s);
                if (cells_s[idx_s] != anchor_cell_s) begin
                    match_s = 1'b0;
                end else begin
                    match_s = match_s;
                end
            end else begin
                match_s = 1'b0;
            end
        end
    end

    assign in_range = in_range_s;
    assign match    = match_s;

endmodule

// File: rtl/win_scanner.sv
// Sequential connect-four win scanner: snapshots the board on start and
// evaluates one anchor cell per clock in all four directions, lowest anchor
// first. Optional macro CONNECT4_WIN_MASK_EN adds the win_mask output.
module win_scanner
    import connect4_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               start,
    input  logic [BOARD_W-1:0] board,
    output logic               busy,
    output logic               done,
    output logic [1:0]         winner,
    output logic [5:0]         win_anchor,
    output logic [1:0]         win_dir
`ifdef CONNECT4_WIN_MASK_EN
    ,
    output logic [NCELLS-1:0]  win_mask
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCELLS - 1);
    localparam logic [2:0]       LAST_COL = 3'(COLS - 1);

    state_t             state_r;
    logic [BOARD_W-1:0] snap_r;
    logic [IDX_W-1:0]   anchor_r;
    logic [2:0]         row_r;
    logic [2:0]         col_r;
    logic               busy_r;
    logic               done_r;
    logic [1:0]         winner_r;
    logic [IDX_W-1:0]   win_anchor_r;
    logic [1:0]         win_dir_r;
    logic [NCELLS-1:0]  mask_r;

    logic [3:0]         in_range_s;
    logic [3:0]         match_s;
    logic               hit_s;
    logic [1:0]         hit_dir_s;
    logic [1:0]         cells_s [NCELLS];
    logic [1:0]         anchor_cell_s;
    logic               full_s;
    logic [NCELLS-1:0]  mask_s;
    int                 step_s;

    for (genvar j = 0; j < NCELLS; j++) begin : g_cell
        assign cells_s[j] = cell_clean(snap_r[2*(NCELLS-1-j) +: 2]);
    end

    win_line_check u_chk_h (.snap(snap_r), .row(row_r), .col(col_r), .dir(DIR_H),
                            .in_range(in_range_s[0]), .match(match_s[0]));
    win_line_check u_chk_v (.snap(snap_r), .row(row_r), .col(col_r), .dir(DIR_V),
                            .in_range(in_range_s[1]), .match(match_s[1]));
    win_line_check u_chk_d (.snap(snap_r), .row(row_r), .col(col_r), .dir(DIR_D),
                            .in_range(in_range_s[2]), .match(match_s[2]));
    win_line_check u_chk_a (.snap(snap_r), .row(row_r), .col(col_r), .dir(DIR_A),
                            .in_range(in_range_s[3]), .match(match_s[3]));

    // Direction priority within one anchor: H > V > D > A.
    always_comb begin
        hit_s     = 1'b0;
        hit_dir_s = DIR_H;
        if (in_range_s[0] && match_s[0]) begin
            hit_s = 1'b1; hit_dir_s = DIR_H;
        end else if (in_range_s[1] && match_s[1]) begin
            hit_s = 1'b1; hit_dir_s = DIR_V;
        end else if (in_range_s[2] && match_s[2]) begin
            hit_s = 1'b1; hit_dir_s = DIR_D;
        end else if (in_range_s[3] && match_s[3]) begin
            hit_s = 1'b1; hit_dir_s = DIR_A;
        end else begin
            hit_s = 1'b0; hit_dir_s = DIR_H;
        end
    end

    // Anchor cell value (becomes the winner code) and board-full test for draws.
    always_comb begin
        anchor_cell_s = cells_s[anchor_r];
        full_s        = 1'b1;
        for (int j = 0; j < NCELLS; j++) begin
            if (cells_s[j] == CELL_EMPTY) begin
                full_s = 1'b0;
            end else begin
                full_s = full_s;
            end
        end
    end

    // Cells covered by the line found at the current anchor.
    always_comb begin
        mask_s = '0;
        case (hit_dir_s)
            DIR_H:   step_s = 1;
            DIR_V:   step_s = COLS;
            DIR_D:   step_s = COLS + 1;
            DIR_A:   step_s = COLS - 1;
            default: step_s = 1;
        endcase
        for (int i = 0; i < WIN_LEN; i++) begin
            for (int j = 0; j < NCELLS; j++) begin
                if (int'(anchor_r) + i * step_s == j) begin
                    mask_s[j] = 1'b1;
                end else begin
                    mask_s[j] = mask_s[j];
                end
            end
        end
    end

    // Scanner FSM with all outputs registered.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            snap_r       <= '0;
            anchor_r     <= '0;
            row_r        <= 3'd0;
            col_r        <= 3'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            winner_r     <= RES_NONE;
            win_anchor_r <= '0;
            win_dir_r    <= DIR_H;
            mask_r       <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        snap_r       <= board;
                        anchor_r     <= '0;
                        row_r        <= 3'd0;
                        col_r        <= 3'd0;
                        busy_r       <= 1'b1;
                        winner_r     <= RES_NONE;
                        win_anchor_r <= '0;
                        win_dir_r    <= DIR_H;
                        mask_r       <= '0;
                        state_r      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit_s) begin
                        winner_r     <= anchor_cell_s;
                        win_anchor_r <= anchor_r;
                        win_dir_r    <= hit_dir_s;
                        mask_r       <= mask_s;
                        done_r       <= 1'b1;
                        state_r      <= ST_DONE;
                    end else if (anchor_r == LAST_IDX) begin
                        winner_r     <= full_s ? RES_DRAW : RES_NONE;
                        win_anchor_r <= '0;
                        win_dir_r    <= DIR_H;
                        mask_r       <= '0;
                        done_r       <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        anchor_r <= anchor_r + 6'd1;
                        if (col_r == LAST_COL) begin
                            col_r <= 3'd0;
                            row_r <= row_r + 3'd1;
                        end else begin
                            col_r <= col_r + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign winner     = winner_r;
    assign win_anchor = win_anchor_r;
    assign win_dir    = win_dir_r;
`ifdef CONNECT4_WIN_MASK_EN
    assign win_mask   = mask_r;
`else
    logic unused_mask_s;
    assign unused_mask_s = ^mask_r;
`endif

endmodule

// File: tb/tb_win_scanner.sv
// Self-checking bench for win_scanner: directed boards plus random boards,
// checked against a grid-level reference model of the winning rules.
module tb_win_scanner;

    localparam int R = 7;
    localparam int C = 7;
    localparam int N = 49;

    logic        CLOCK_50 = 1'b0;
    logic        resetn   = 1'b0;
    logic        start    = 1'b0;
    logic [97:0] board    = '0;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic [5:0]  win_anchor;
    logic [1:0]  win_dir;
`ifdef CONNECT4_WIN_MASK_EN
    logic [48:0] win_mask;
`endif

    int total = 0;
    int bad   = 0;
    int g [R][C];

    win_scanner dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .start     (start),
        .board     (board),
        .busy      (busy),
        .done      (done),
        .winner    (winner),
        .win_anchor(win_anchor),
        .win_dir   (win_dir)
`ifdef CONNECT4_WIN_MASK_EN
        ,
        .win_mask  (win_mask)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_grid();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                g[r][c] = 0;
    endtask

    task automatic put(input int k, input int v);
        g[k / C][k % C] = v;
    endtask

    function automatic logic [97:0] pack();
        logic [97:0] b;
        b = '0;
        for (int k = 0; k < N; k++)
            b = {b[95:0], 2'(g[k / C][k % C])};
        return b;
    endfunction

    // Reference: first (anchor, direction) in priority order whose four
    // cells lie on the board and hold the same player; else draw/none.
    task automatic model(output int w, output int a, output int d, output logic [48:0] m);
        int  dr [4];
        int  dc [4];
        bit  found;
        bit  ok;
        bit  full;
        int  v;
        int  rr;
        int  cc;
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        w = 0; a = 0; d = 0; m = '0; found = 0;
        for (int k = 0; k < N; k++) begin
            v = g[k / C][k % C];
            if (!found && (v == 1 || v == 2)) begin
                for (int dd = 0; dd < 4; dd++) begin
                    if (!found) begin
                        ok = 1;
                        for (int i = 1; i < 4; i++) begin
                            rr = k / C + dr[dd] * i;
                            cc = k % C + dc[dd] * i;
                            if (rr < 0 || rr >= R || cc < 0 || cc >= C) ok = 0;
                            else if (g[rr][cc] != v) ok = 0;
                        end
                        if (ok) begin
                            found = 1; w = v; a = k; d = dd;
                            for (int i = 0; i < 4; i++)
                                m = m | (49'd1 << ((k / C + dr[dd] * i) * C + (k % C + dc[dd] * i)));
                        end
                    end
                end
            end
        end
        if (!found) begin
            full = 1;
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    if (!(g[r][c] == 1 || g[r][c] == 2)) full = 0;
            w = full ? 3 : 0;
        end
    endtask

    // One scan of the current grid; poke > 0 pulses start that many cycles in.
    task automatic run_scan(input string tag, input int poke);
        int          ew, ea, ed, elat, n;
        logic [48:0] em;
        bit          seen, busy_ok;
        model(ew, ea, ed, em);
        elat = (ew == 1 || ew == 2) ? ea + 2 : 50;
        @(negedge CLOCK_50);
        board = pack();
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        board = ~board;
        chk({tag, "/busy_on"}, 64'(busy), 64'd1);
        chk({tag, "/cleared"}, 64'({winner, win_anchor, win_dir}), 64'd0);
        n = 1; seen = 0; busy_ok = 1;
        while (!seen && n <= 60) begin
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                if (busy !== 1'b1) busy_ok = 0;
                start = (n == poke);
                @(posedge CLOCK_50); #1;
                n++;
            end
        end
        start = 1'b0;
        chk({tag, "/done_seen"}, 64'(seen), 64'd1);
        chk({tag, "/latency"}, 64'(n), 64'(elat));
        chk({tag, "/busy_scan"}, 64'(busy_ok), 64'd1);
        chk({tag, "/busy_done"}, 64'(busy), 64'd1);
        chk({tag, "/winner"}, 64'(winner), 64'(ew));
        chk({tag, "/anchor"}, 64'(win_anchor), 64'(ea));
        chk({tag, "/dir"}, 64'(win_dir), 64'(ed));
`ifdef CONNECT4_WIN_MASK_EN
        chk({tag, "/mask"}, 64'(win_mask), 64'(em));
`endif
        @(posedge CLOCK_50); #1;
        chk({tag, "/done_pulse"}, 64'(done), 64'd0);
        chk({tag, "/busy_off"}, 64'(busy), 64'd0);
        chk({tag, "/hold"}, 64'(winner), 64'(ew));
    endtask

    initial begin
        bit done_leak;
        // Reset state
        #12;
        chk("rst/busy", 64'(busy), 64'd0);
        chk("rst/done", 64'(done), 64'd0);
        chk("rst/result", 64'({winner, win_anchor, win_dir}), 64'd0);
`ifdef CONNECT4_WIN_MASK_EN
        chk("rst/mask", 64'(win_mask), 64'd0);
`endif
        @(negedge CLOCK_50);
        resetn = 1'b1;

        // Empty board: full 49-anchor scan, no winner
        clear_grid();
        run_scan("empty", 0);

        // Bottom-row horizontal P1
        clear_grid();
        for (int k = 42; k <= 45; k++) put(k, 1);
        run_scan("hrow6", 0);
        chk("hrow6/const_anchor", 64'(win_anchor), 64'd42);

        // Anti-diagonal P2 from (2,6) beats a later P1 horizontal
        clear_grid();
        put(20, 2); put(26, 2); put(32, 2); put(38, 2);
        for (int k = 45; k <= 48; k++) put(k, 1);
        run_scan("anti", 0);
        chk("anti/const_winner", 64'(winner), 64'd2);
        chk("anti/const_dir", 64'(win_dir), 64'd3);

        // Run wrapping from row 5 into row 6 must not count
        clear_grid();
        for (int k = 40; k <= 43; k++) put(k, 1);
        run_scan("wrap", 0);
        chk("wrap/const_winner", 64'(winner), 64'd0);

        // Illegal code 11 in a line acts as empty
        clear_grid();
        for (int k = 0; k <= 3; k++) put(k, 3);
        run_scan("illegal", 0);

        // Full board without any four-in-line: draw
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                g[r][c] = 1 + (((c >> 1) + r) & 1);
        run_scan("draw", 0);
        chk("draw/const_winner", 64'(winner), 64'd3);

        // Vertical P1 in column 0
        clear_grid();
        put(21, 1); put(28, 1); put(35, 1); put(42, 1);
        run_scan("vert", 0);
        chk("vert/const_dir", 64'(win_dir), 64'd1);

        // Start pulsed while busy is ignored
        clear_grid();
        for (int k = 42; k <= 45; k++) put(k, 2);
        run_scan("busy_start", 5);

        // Reset mid-scan aborts with no done pulse
        clear_grid();
        @(negedge CLOCK_50);
        board = pack();
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        repeat (10) @(posedge CLOCK_50);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst/busy", 64'(busy), 64'd0);
        chk("midrst/done", 64'(done), 64'd0);
        chk("midrst/result", 64'({winner, win_anchor, win_dir}), 64'd0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        done_leak = 0;
        repeat (60) begin
            @(posedge CLOCK_50); #1;
            if (done !== 1'b0 || busy !== 1'b0) done_leak = 1;
        end
        chk("midrst/no_done", 64'(done_leak), 64'd0);

        // Random boards (codes 0..3, weighted toward empty)
        for (int it = 0; it < 20; it++) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    g[r][c] = ($urandom_range(0, 9) < 4) ? 0 : int'($urandom_range(1, 3));
            run_scan("random", 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
